// File: rtl/goose_pkg.sv
// Shared types and display constants for the goose VGA sprite path.
package goose_pkg;

    typedef enum logic [1:0] {
        AnimLoop     = 2'b00,
        AnimPingpong = 2'b01,
        AnimHold     = 2'b10,
        AnimStep     = 2'b11
    } anim_mode_t;

    localparam int unsigned H_ACTIVE   = 640;
    localparam int unsigned V_ACTIVE   = 480;
    localparam int unsigned NUM_FRAMES = 4;
    localparam int unsigned FRAME_W    = 2;

endpackage

// File: rtl/goose_bounce_counter.sv
// Clamped up/down counter: saturates at 0 and MAX, reversing direction when it hits either end.
module goose_bounce_counter #(
    parameter int unsigned W    = 10,
    parameter logic [W-1:0] MAX = W'(256),
    parameter logic [W-1:0] STEP = W'(2)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] value
);

    logic         down_q;
    logic [W-1:0] value_d;
    logic         down_d;
    logic [W:0]   sum;

    // One bit wider than the counter so value+STEP near the top cannot wrap.
    assign sum = {1'b0, value} + {1'b0, STEP};

    always_comb begin
        value_d = value;
        down_d  = down_q;
        if (en) begin
            if (!down_q) begin
                if (sum >= {1'b0, MAX}) begin
                    value_d = MAX;
                    down_d  = 1'b1;
                end else begin
                    value_d = sum[W-1:0];
                end
            end else begin
                if (value <= STEP) begin
                    value_d = '0;
                    down_d  = 1'b0;
                end else begin
                    value_d = value - STEP;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            value  <= '0;
            down_q <= 1'b0;
        end else begin
            value  <= value_d;
            down_q <= down_d;
        end
    end

endmodule

// File: rtl/goose_anim_sequencer.sv
// Per-frame animation scheduler: picks the sprite frame and horizontal offset during vblank.
module goose_anim_sequencer #(
    parameter int unsigned NUM_FRAMES = goose_pkg::NUM_FRAMES,
    parameter int unsigned FRAME_W    = goose_pkg::FRAME_W,
    parameter int unsigned V_ACTIVE   = goose_pkg::V_ACTIVE,
    parameter logic [9:0]  X_MAX      = 10'd256,
    parameter logic [9:0]  X_STEP     = 10'd2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [9:0]            pix_x,
    input  logic [9:0]            pix_y,
    input  logic                  en,
    input  goose_pkg::anim_mode_t mode,
    input  logic [3:0]            speed,
    input  logic                  step,
    output logic [FRAME_W-1:0]    frame_sel,
    output logic [9:0]            x_offset,
    output logic                  dir,
    output logic                  adv_pulse
);

    import goose_pkg::*;

    localparam logic [FRAME_W-1:0] LAST = FRAME_W'(NUM_FRAMES - 1);

    logic               tick;
    logic               run_tick;
    logic               adv;
    logic               step_q;
    logic               step_pend;
    logic               step_pend_d;
    logic [3:0]         div_cnt;
    logic [3:0]         div_cnt_d;
    logic [FRAME_W-1:0] frame_d;
    logic [FRAME_W-1:0] frame_nxt;
    logic               dir_d;
    logic               dir_eff;

    assign tick     = (pix_y == 10'(V_ACTIVE)) && (pix_x == 10'd0);
    assign run_tick = tick && en;

    // A rising step edge is remembered until the next enabled tick, whatever the mode.
    assign step_pend_d = (step_pend && !run_tick) || (step && !step_q);

    always_comb begin
        adv       = 1'b0;
        div_cnt_d = div_cnt;
        if (run_tick) begin
            unique case (mode)
                AnimLoop, AnimPingpong: begin
                    // >= so that lowering speed mid-count advances right away.
                    if (div_cnt >= speed) begin
                        adv       = 1'b1;
                        div_cnt_d = '0;
                    end else begin
                        div_cnt_d = div_cnt + 4'd1;
                    end
                end
                AnimHold: div_cnt_d = '0;
                AnimStep: adv = step_pend;
            endcase
        end
    end

    // Ping-pong direction, forced inward when sitting at either end.
    always_comb begin
        if (frame_sel == '0) begin
            dir_eff = 1'b0;
        end else if (frame_sel == LAST) begin
            dir_eff = 1'b1;
        end else begin
            dir_eff = dir;
        end
        frame_nxt = dir_eff ? frame_sel - FRAME_W'(1) : frame_sel + FRAME_W'(1);
    end

    always_comb begin
        frame_d = frame_sel;
        dir_d   = dir;
        if (adv) begin
            if (NUM_FRAMES <= 1) begin
                frame_d = '0;
                dir_d   = 1'b0;
            end else if (mode == AnimPingpong) begin
                frame_d = frame_nxt;
                if (frame_nxt == LAST) begin
                    dir_d = 1'b1;
                end else if (frame_nxt == '0) begin
                    dir_d = 1'b0;
                end else begin
                    dir_d = dir_eff;
                end
            end else begin
                frame_d = (frame_sel == LAST) ? '0 : frame_sel + FRAME_W'(1);
                dir_d   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_sel <= '0;
            dir       <= 1'b0;
            div_cnt   <= '0;
            step_q    <= 1'b0;
            step_pend <= 1'b0;
            adv_pulse <= 1'b0;
        end else begin
            frame_sel <= frame_d;
            dir       <= dir_d;
            div_cnt   <= div_cnt_d;
            step_q    <= step;
            step_pend <= step_pend_d;
            adv_pulse <= adv;
        end
    end

    goose_bounce_counter #(
        .W    (10),
        .MAX  (X_MAX),
        .STEP (X_STEP)
    ) u_x_bounce (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (adv),
        .value (x_offset)
    );

endmodule

// File: tb/tb_goose_anim_sequencer.sv
// Directed vector table, hand-written corner sequences and a randomized run against a frame-level model.
module tb_goose_anim_sequencer;
    import goose_pkg::*;

    localparam int NF = 4;
    localparam int XM = 10;
    localparam int XS = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    anim_mode_t mode;
    logic [3:0] speed;
    logic       step;
    logic [9:0] pix_x;
    logic [9:0] pix_y;
    logic [1:0] frame_sel;
    logic [9:0] x_offset;
    logic       dir;
    logic       adv_pulse;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    goose_anim_sequencer #(
        .NUM_FRAMES (NF),
        .FRAME_W    (2),
        .V_ACTIVE   (480),
        .X_MAX      (10'd10),
        .X_STEP     (10'd4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .en        (en),
        .mode      (mode),
        .speed     (speed),
        .step      (step),
        .frame_sel (frame_sel),
        .x_offset  (x_offset),
        .dir       (dir),
        .adv_pulse (adv_pulse)
    );

    typedef struct {
        bit         rst_n;
        bit         en;
        anim_mode_t mode;
        logic [3:0] speed;
        bit         step;
        bit         tick;
        logic [1:0] f;
        logic [9:0] x;
        bit         d;
        bit         p;
    } vec_t;

    vec_t vecs[$];

    // Behavioural model state
    int m_frame, m_dir, m_x, m_xdir, m_div, m_stepq, m_pend, m_pulse;

    function automatic void add(bit r, bit e, anim_mode_t m, int s, bit st, bit t,
                                int f, int x, bit d, bit p);
        vec_t v;
        v.rst_n = r; v.en = e; v.mode = m; v.speed = 4'(s); v.step = st; v.tick = t;
        v.f = 2'(f); v.x = 10'(x); v.d = d; v.p = p;
        vecs.push_back(v);
    endfunction

    task automatic set_pix(input bit t);
        if (t) begin
            pix_x = 10'd0;
            pix_y = 10'd480;
        end else if ($urandom_range(0, 1) == 0) begin
            pix_x = 10'd1;
            pix_y = 10'd480;
        end else begin
            pix_x = 10'd0;
            pix_y = 10'd479;
        end
    endtask

    task automatic apply(input bit r, input bit e, input anim_mode_t m, input int s,
                         input bit st, input bit t);
        rst_n = r; en = e; mode = m; speed = 4'(s); step = st;
        set_pix(t);
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int f, input int x, input bit d, input bit p);
        compared++;
        if (frame_sel !== 2'(f) || x_offset !== 10'(x) || dir !== d || adv_pulse !== p) begin
            mismatched++;
            $display("FAIL %s: got frame=%0d x=%0d dir=%0b pulse=%0b, want frame=%0d x=%0d dir=%0b pulse=%0b",
                     name, frame_sel, x_offset, dir, adv_pulse, f, x, d, p);
        end
    endtask

    // Frame-level reference: ping-pong is a position on a cycle of length 2*(NF-1).
    task automatic model_step();
        bit tk, rise, adv;
        int p;
        if (!rst_n) begin
            m_frame = 0; m_dir = 0; m_x = 0; m_xdir = 0;
            m_div = 0; m_stepq = 0; m_pend = 0; m_pulse = 0;
            return;
        end
        tk   = (pix_y == 10'd480) && (pix_x == 10'd0);
        rise = step && (m_stepq == 0);
        adv  = 1'b0;
        if (tk && en) begin
            if (mode == AnimLoop || mode == AnimPingpong) begin
                if (m_div >= int'(speed)) begin
                    adv = 1'b1;
                    m_div = 0;
                end else begin
                    m_div++;
                end
            end else if (mode == AnimHold) begin
                m_div = 0;
            end else begin
                adv = (m_pend != 0);
            end
            m_pend = 0;
        end
        if (rise) m_pend = 1;
        m_stepq = step;
        if (adv) begin
            if (mode == AnimPingpong) begin
                if (m_frame == 0 || (m_dir == 0 && m_frame != NF - 1)) p = m_frame;
                else p = 2 * NF - 2 - m_frame;
                p = (p + 1) % (2 * NF - 2);
                m_frame = (p < NF) ? p : 2 * NF - 2 - p;
                m_dir = (p >= NF - 1) ? 1 : 0;
            end else begin
                m_frame = (m_frame + 1) % NF;
                m_dir = 0;
            end
            if (m_xdir == 0) begin
                if (m_x + XS >= XM) begin
                    m_x = XM;
                    m_xdir = 1;
                end else begin
                    m_x += XS;
                end
            end else begin
                if (m_x <= XS) begin
                    m_x = 0;
                    m_xdir = 0;
                end else begin
                    m_x -= XS;
                end
            end
        end
        m_pulse = adv;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; mode = AnimLoop; speed = 4'd0; step = 1'b0;
        set_pix(1'b0);

        apply(0, 0, AnimLoop, 0, 0, 0);
        apply(0, 0, AnimLoop, 0, 0, 0);
        check("reset_state", 0, 0, 0, 0);

        // LOOP speed 0: frames 1,2,3,0,1,2,3 and x bounce 4,8,10,6,2,0,4
        add(1, 1, AnimLoop, 0, 0, 1, 1, 4, 0, 1);  add(1, 1, AnimLoop, 0, 0, 0, 1, 4, 0, 0);
        add(1, 1, AnimLoop, 0, 0, 1, 2, 8, 0, 1);  add(1, 1, AnimLoop, 0, 0, 0, 2, 8, 0, 0);
        add(1, 1, AnimLoop, 0, 0, 1, 3, 10, 0, 1); add(1, 1, AnimLoop, 0, 0, 0, 3, 10, 0, 0);
        add(1, 1, AnimLoop, 0, 0, 1, 0, 6, 0, 1);  add(1, 1, AnimLoop, 0, 0, 0, 0, 6, 0, 0);
        add(1, 1, AnimLoop, 0, 0, 1, 1, 2, 0, 1);  add(1, 1, AnimLoop, 0, 0, 0, 1, 2, 0, 0);
        add(1, 1, AnimLoop, 0, 0, 1, 2, 0, 0, 1);  add(1, 1, AnimLoop, 0, 0, 0, 2, 0, 0, 0);
        add(1, 1, AnimLoop, 0, 0, 1, 3, 4, 0, 1);
        add(0, 1, AnimLoop, 0, 0, 1, 0, 0, 0, 0);
        // PINGPONG speed 1, 12 ticks
        add(1, 1, AnimPingpong, 1, 0, 1, 0, 0, 0, 0);  add(1, 1, AnimPingpong, 1, 0, 1, 1, 4, 0, 1);
        add(1, 1, AnimPingpong, 1, 0, 1, 1, 4, 0, 0);  add(1, 1, AnimPingpong, 1, 0, 1, 2, 8, 0, 1);
        add(1, 1, AnimPingpong, 1, 0, 1, 2, 8, 0, 0);  add(1, 1, AnimPingpong, 1, 0, 1, 3, 10, 1, 1);
        add(1, 1, AnimPingpong, 1, 0, 1, 3, 10, 1, 0); add(1, 1, AnimPingpong, 1, 0, 1, 2, 6, 1, 1);
        add(1, 1, AnimPingpong, 1, 0, 1, 2, 6, 1, 0);  add(1, 1, AnimPingpong, 1, 0, 1, 1, 2, 1, 1);
        add(1, 1, AnimPingpong, 1, 0, 1, 1, 2, 1, 0);  add(1, 1, AnimPingpong, 1, 0, 1, 0, 0, 0, 1);
        // STEP: held level gives one advance
        add(1, 1, AnimStep, 1, 1, 0, 0, 0, 0, 0);
        add(1, 1, AnimStep, 1, 1, 1, 1, 4, 0, 1);
        for (int i = 0; i < 4; i++) add(1, 1, AnimStep, 1, 1, 1, 1, 4, 0, 0);
        // two step pulses before one tick
        add(1, 1, AnimStep, 1, 0, 0, 1, 4, 0, 0); add(1, 1, AnimStep, 1, 1, 0, 1, 4, 0, 0);
        add(1, 1, AnimStep, 1, 0, 0, 1, 4, 0, 0); add(1, 1, AnimStep, 1, 1, 0, 1, 4, 0, 0);
        add(1, 1, AnimStep, 1, 0, 0, 1, 4, 0, 0);
        add(1, 1, AnimStep, 1, 0, 1, 2, 8, 0, 1); add(1, 1, AnimStep, 1, 0, 1, 2, 8, 0, 0);
        // pending step survives ticks while disabled
        add(1, 1, AnimStep, 1, 1, 0, 2, 8, 0, 0);
        for (int i = 0; i < 3; i++) add(1, 0, AnimStep, 1, 1, 1, 2, 8, 0, 0);
        add(1, 1, AnimStep, 1, 0, 1, 3, 10, 0, 1);
        add(1, 1, AnimHold, 0, 0, 1, 3, 10, 0, 0);
        // entering PINGPONG at the top end turns inward
        add(1, 1, AnimPingpong, 0, 0, 1, 2, 6, 1, 1);
        add(1, 1, AnimLoop, 0, 0, 1, 3, 2, 0, 1);

        foreach (vecs[i]) begin
            apply(vecs[i].rst_n, vecs[i].en, vecs[i].mode, vecs[i].speed, vecs[i].step, vecs[i].tick);
            check($sformatf("vec%0d", i), vecs[i].f, vecs[i].x, vecs[i].d, vecs[i].p);
        end

        // Lowering speed mid-count advances on the very next tick
        apply(0, 1, AnimLoop, 15, 0, 0);
        for (int i = 0; i < 9; i++) begin
            apply(1, 1, AnimLoop, 15, 0, 1);
            check("speed15_count", 0, 0, 0, 0);
        end
        apply(1, 1, AnimLoop, 2, 0, 1);
        check("speed_drop_adv", 1, 4, 0, 1);
        apply(1, 1, AnimLoop, 2, 0, 1);
        check("speed_drop_div0_a", 1, 4, 0, 0);
        apply(1, 1, AnimLoop, 2, 0, 1);
        check("speed_drop_div0_b", 1, 4, 0, 0);
        apply(1, 1, AnimLoop, 2, 0, 1);
        check("speed_drop_next", 2, 8, 0, 1);

        // Mid-run reset with tick and step on the same edges
        apply(0, 1, AnimPingpong, 0, 0, 0);
        for (int i = 0; i < 4; i++) apply(1, 1, AnimPingpong, 0, 0, 1);
        check("pre_reset", 2, 6, 1, 1);
        apply(1, 1, AnimPingpong, 0, 1, 0);
        apply(0, 1, AnimStep, 0, 1, 1);
        apply(0, 1, AnimStep, 0, 1, 1);
        check("reset_mid", 0, 0, 0, 0);
        apply(1, 1, AnimStep, 0, 0, 1);
        check("reset_clears_pend", 0, 0, 0, 0);

        // Randomized run against the model
        for (int i = 0; i < 4000; i++) begin
            rst_n = (i == 0) ? 1'b0 : ($urandom_range(0, 299) != 0);
            en    = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 39) == 0) mode = anim_mode_t'($urandom_range(0, 3));
            if ($urandom_range(0, 39) == 0) speed = 4'($urandom_range(0, 4));
            if ($urandom_range(0, 3) == 0) step = ~step;
            set_pix($urandom_range(0, 2) == 0);
            @(posedge clk);
            model_step();
            #1;
            check("random", m_frame, m_x, m_dir[0], m_pulse[0]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
